// File: rtl/seq_det_param_if.sv
//------------------------------------------------------------------------------
// Module : seq_det_param_if
// Brief  : Stream, configuration and result signals of the pattern detector.
//          SEQ_DET_MASK_EN adds the per-bit compare mask input cfg_mask.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_det_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pat;
    logic             cfg_overlap;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] cfg_mask;
`endif
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    modport master (
`ifdef SEQ_DET_MASK_EN
        output cfg_mask,
`endif
        output in_valid, in_bit, cfg_we, cfg_pat, cfg_overlap, cnt_clr,
        input  match, match_cnt, armed
    );

    modport slave (
`ifdef SEQ_DET_MASK_EN
        input  cfg_mask,
`endif
        input  in_valid, in_bit, cfg_we, cfg_pat, cfg_overlap, cnt_clr,
        output match, match_cnt, armed
    );
endinterface

`default_nettype wire

// File: rtl/seq_det_param.sv
//------------------------------------------------------------------------------
// Module : seq_det_param
// Brief  : Runtime-programmable serial pattern detector with overlap select,
//          registered match pulse and saturating match counter.
//          Optional: SEQ_DET_MASK_EN adds a per-bit don't-care compare mask.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_det_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  wire               clk,
    input  wire               rst,
    seq_det_param_if.slave    bus
);
    localparam int                 FILL_W  = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]  c_FULL  = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0]  c_ONE   = FILL_W'(1);

    // Configuration registers
    logic [PAT_W-1:0]  r_pat;
    logic              r_overlap;
    logic [PAT_W-1:0]  r_mask;

    // Detector state
    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_match;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_armed;

    // Next-state values
    logic [PAT_W-1:0]  w_pat_nxt;
    logic              w_overlap_nxt;
    logic [PAT_W-1:0]  w_mask_nxt;
    logic [PAT_W-1:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              w_match_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [PAT_W-1:0]  w_candidate;
    logic [FILL_W-1:0] w_fill_inc;
    logic              w_cmp_eq;
    logic              w_hit;

    assign w_candidate = {r_hist[PAT_W-2:0], bus.in_bit};
    assign w_fill_inc  = (r_fill == c_FULL) ? c_FULL : (r_fill + c_ONE);

`ifdef SEQ_DET_MASK_EN
    assign w_cmp_eq = (((w_candidate ^ r_pat) & r_mask) == '0);
`else
    assign w_cmp_eq = (w_candidate == r_pat);
`endif

    // A bit arriving with cfg_we is discarded, so it can never complete a hit.
    assign w_hit = bus.in_valid && !bus.cfg_we && (w_fill_inc == c_FULL) && w_cmp_eq;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat     <= '0;
            r_overlap <= 1'b1;
            r_mask    <= '1;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_cnt     <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_pat     <= w_pat_nxt;
            r_overlap <= w_overlap_nxt;
            r_mask    <= w_mask_nxt;
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_match   <= w_match_nxt;
            r_cnt     <= w_cnt_nxt;
            r_armed   <= (w_fill_nxt == c_FULL);
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_pat_nxt     = r_pat;
        w_overlap_nxt = r_overlap;
        w_mask_nxt    = r_mask;
        w_hist_nxt    = r_hist;
        w_fill_nxt    = r_fill;
        w_match_nxt   = w_hit;
        w_cnt_nxt     = r_cnt;

        if (bus.cfg_we) begin
            w_pat_nxt     = bus.cfg_pat;
            w_overlap_nxt = bus.cfg_overlap;
`ifdef SEQ_DET_MASK_EN
            w_mask_nxt    = bus.cfg_mask;
`else
            w_mask_nxt    = '1;
`endif
            w_hist_nxt    = '0;
            w_fill_nxt    = '0;
        end else if (bus.in_valid) begin
            if (w_hit && !r_overlap) begin
                w_hist_nxt = '0;
                w_fill_nxt = '0;
            end else begin
                w_hist_nxt = w_candidate;
                w_fill_nxt = w_fill_inc;
            end
        end

        // Clear beats a coincident hit; that hit still pulses match.
        if (bus.cnt_clr) begin
            w_cnt_nxt = '0;
        end else if (w_hit && !(&r_cnt)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    always_comb begin
        bus.match     = r_match;
        bus.match_cnt = r_cnt;
        bus.armed     = r_armed;
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_det_param.sv
//------------------------------------------------------------------------------
// Module : tb_seq_det_param
// Brief  : Directed self-checking bench for seq_det_param (PAT_W=4, CNT_W=2).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_det_param;
    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic             m;
        logic [CNT_W-1:0] c;
        logic             a;
    } exp_t;

    exp_t  exp_q[$];
    string tag;

    seq_det_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) sif ();

    seq_det_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        exp_t e;
        total += 1;
        assert (exp_q.size() > 0) else begin
            bad += 1;
            $error("FAIL %s queue: observed=empty expected=entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total += 3;
            assert (sif.match === e.m) else begin
                bad += 1;
                $error("FAIL %s match: observed=%0b expected=%0b", tag, sif.match, e.m);
            end
            assert (sif.match_cnt === e.c) else begin
                bad += 1;
                $error("FAIL %s match_cnt: observed=%0d expected=%0d", tag, sif.match_cnt, e.c);
            end
            assert (sif.armed === e.a) else begin
                bad += 1;
                $error("FAIL %s armed: observed=%0b expected=%0b", tag, sif.armed, e.a);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs after the edge, compare.
    task automatic step(input string t, input logic r, input logic v, input logic b,
                        input logic we, input logic [PAT_W-1:0] pat, input logic ovl,
                        input logic clr, input logic em, input int ec, input logic ea);
        exp_t e;
        tag             = t;
        rst             = r;
        sif.in_valid    = v;
        sif.in_bit      = b;
        sif.cfg_we      = we;
        sif.cfg_pat     = pat;
        sif.cfg_overlap = ovl;
        sif.cnt_clr     = clr;
        e.m = em;
        e.c = CNT_W'(ec);
        e.a = ea;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic bit_in(input string t, input logic b, input logic em, input int ec, input logic ea);
        step(t, 1'b0, 1'b1, b, 1'b0, 4'b0000, 1'b0, 1'b0, em, ec, ea);
    endtask

    task automatic idle(input string t, input int ec, input logic ea);
        step(t, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, ec, ea);
    endtask

    initial begin
`ifdef SEQ_DET_MASK_EN
        sif.cfg_mask = '1;
`endif
        // Reset
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Overlap, pattern 1011, stream 1011011 -> two hits
        step("cfg_ov", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        bit_in("ov_b1", 1'b1, 1'b0, 0, 1'b0);
        bit_in("ov_b2", 1'b0, 1'b0, 0, 1'b0);
        bit_in("ov_b3", 1'b1, 1'b0, 0, 1'b0);
        bit_in("ov_b4", 1'b1, 1'b1, 1, 1'b1);
        bit_in("ov_b5", 1'b0, 1'b0, 1, 1'b1);
        bit_in("ov_b6", 1'b1, 1'b0, 1, 1'b1);
        bit_in("ov_b7", 1'b1, 1'b1, 2, 1'b1);
        idle("ov_idle", 2, 1'b1);

        // Non-overlap, same stream -> one hit, armed drops after it
        step("cfg_nov", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        bit_in("nov_b1", 1'b1, 1'b0, 0, 1'b0);
        bit_in("nov_b2", 1'b0, 1'b0, 0, 1'b0);
        bit_in("nov_b3", 1'b1, 1'b0, 0, 1'b0);
        bit_in("nov_b4", 1'b1, 1'b1, 1, 1'b0);
        bit_in("nov_b5", 1'b0, 1'b0, 1, 1'b0);
        bit_in("nov_b6", 1'b1, 1'b0, 1, 1'b0);
        bit_in("nov_b7", 1'b1, 1'b0, 1, 1'b0);

        // Gaps of in_valid=0 inside the pattern
        step("cfg_gap", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        bit_in("gap_b1", 1'b1, 1'b0, 0, 1'b0);
        bit_in("gap_b2", 1'b0, 1'b0, 0, 1'b0);
        bit_in("gap_b3", 1'b1, 1'b0, 0, 1'b0);
        idle("gap_i1", 0, 1'b0);
        idle("gap_i2", 0, 1'b0);
        idle("gap_i3", 0, 1'b0);
        bit_in("gap_b4", 1'b1, 1'b1, 1, 1'b1);
        idle("gap_after", 1, 1'b1);

        // Counter saturation at 3 with pattern 1111 and eight ones
        step("cfg_sat", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        bit_in("sat_b1", 1'b1, 1'b0, 0, 1'b0);
        bit_in("sat_b2", 1'b1, 1'b0, 0, 1'b0);
        bit_in("sat_b3", 1'b1, 1'b0, 0, 1'b0);
        bit_in("sat_b4", 1'b1, 1'b1, 1, 1'b1);
        bit_in("sat_b5", 1'b1, 1'b1, 2, 1'b1);
        bit_in("sat_b6", 1'b1, 1'b1, 3, 1'b1);
        bit_in("sat_b7", 1'b1, 1'b1, 3, 1'b1);
        bit_in("sat_b8", 1'b1, 1'b1, 3, 1'b1);

        // cfg_we mid-pattern flushes history and discards its own bit
        step("cfg_mid0", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        bit_in("mid_p1", 1'b1, 1'b0, 0, 1'b0);
        bit_in("mid_p2", 1'b0, 1'b0, 0, 1'b0);
        bit_in("mid_p3", 1'b1, 1'b0, 0, 1'b0);
        bit_in("mid_p4", 1'b1, 1'b1, 1, 1'b1);
        bit_in("mid_q1", 1'b1, 1'b0, 1, 1'b1);
        bit_in("mid_q2", 1'b0, 1'b0, 1, 1'b1);
        bit_in("mid_q3", 1'b1, 1'b0, 1, 1'b1);
        step("cfg_mid1", 1'b0, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        bit_in("mid_r1", 1'b1, 1'b0, 1, 1'b0);
        bit_in("mid_r2", 1'b0, 1'b0, 1, 1'b0);
        bit_in("mid_r3", 1'b1, 1'b0, 1, 1'b0);
        bit_in("mid_r4", 1'b1, 1'b1, 2, 1'b1);

        // cnt_clr coincident with a hit: pulse still seen, count cleared
        bit_in("clr_b1", 1'b0, 1'b0, 2, 1'b1);
        bit_in("clr_b2", 1'b1, 1'b0, 2, 1'b1);
        step("clr_hit", 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        bit_in("clr_b4", 1'b0, 1'b0, 0, 1'b1);

        // Reset mid-stream restores pattern 0000 / overlap and flushes history
        step("rst_mid", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        bit_in("post_b1", 1'b0, 1'b0, 0, 1'b0);
        bit_in("post_b2", 1'b0, 1'b0, 0, 1'b0);
        bit_in("post_b3", 1'b0, 1'b0, 0, 1'b0);
        bit_in("post_b4", 1'b0, 1'b1, 1, 1'b1);
        bit_in("post_b5", 1'b0, 1'b1, 2, 1'b1);
        idle("post_idle", 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
